fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the control unit / decode.
- Owns the program counter and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned words with their PC in a small in-order queue and presents them to decode on a valid/ready interface.
- Accepts redirects from execute (taken beq, j/jal) and discards stale in-flight fetches.

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of decode.
// Owns the PC, issues word fetches to instruction memory, holds in-order
// returned words with their PC in a small queue, and drops stale fetches
// after a redirect from execute.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   imem_req_valid/ready/addr         fetch request handshake (addr = pc)
//   imem_resp_valid/data              in-order read data from memory
//   redirect, redirect_pc             PC change request from execute
//   inst_valid/ready                  decode handshake on the queue head
//   inst, inst_pc, inst_pc4           head word, its PC, and PC + 4
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          run_q, run_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
  logic [PW-1:0] f_wptr_q, f_wptr_d, f_rptr_q, f_rptr_d;
  logic [31:0]   q_data_q [DEPTH];
  logic [31:0]   q_data_d [DEPTH];
  logic [31:0]   q_pc_q   [DEPTH];
  logic [31:0]   q_pc_d   [DEPTH];
  logic [31:0]   f_pc_q   [DEPTH];
  logic [31:0]   f_pc_d   [DEPTH];

  logic credit, req_fire, resp_fire, push, pop;
  logic unused_rpc_bits;

  assign unused_rpc_bits = ^redirect_pc[1:0];

  // Handshakes, credit and head outputs.
  always_comb begin
    credit         = (SW'(count_q) + SW'(outstanding_q)) < SW'(DEPTH);
    // run_q holds off the first request until the cycle after reset release
    imem_req_valid = run_q && !redirect && credit;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // a response with nothing outstanding is a protocol error and is ignored
    resp_fire      = imem_resp_valid && (outstanding_q != '0);
    push           = resp_fire && (discard_q == '0) && !redirect;
    inst_valid     = (count_q != '0);
    pop            = inst_valid && inst_ready && !redirect;
    inst           = inst_valid ? q_data_q[q_rptr_q] : 32'h0;
    inst_pc        = inst_valid ? q_pc_q[q_rptr_q] : 32'h0;
    inst_pc4       = inst_valid ? (q_pc_q[q_rptr_q] + 32'd4) : 32'h0;
  end

  // Next-state: PC, in-flight PC FIFO, instruction queue, discard counter.
  always_comb begin
    pc_d          = pc_q;
    run_d         = 1'b1;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    q_wptr_d      = q_wptr_q;
    q_rptr_d      = q_rptr_q;
    f_wptr_d      = f_wptr_q;
    f_rptr_d      = f_rptr_q;
    q_data_d      = q_data_q;
    q_pc_d        = q_pc_q;
    f_pc_d        = f_pc_q;

    if (req_fire) begin
      pc_d             = pc_q + 32'd4;
      f_pc_d[f_wptr_q] = pc_q;
      f_wptr_d         = f_wptr_q + PW'(1);
    end
    // every accepted response retires its in-flight PC, dropped or not
    if (resp_fire) begin
      f_rptr_d = f_rptr_q + PW'(1);
    end
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);

    if (redirect) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      count_d   = '0;
      q_wptr_d  = '0;
      q_rptr_d  = '0;
      // everything still in flight after this cycle is stale
      discard_d = outstanding_q - CW'(resp_fire);
    end else begin
      if (resp_fire && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        q_data_d[q_wptr_q] = imem_resp_data;
        q_pc_d[q_wptr_q]   = f_pc_q[f_rptr_q];
        q_wptr_d           = q_wptr_q + PW'(1);
      end
      if (pop) begin
        q_rptr_d = q_rptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      run_q         <= 1'b0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      q_wptr_q      <= '0;
      q_rptr_q      <= '0;
      f_wptr_q      <= '0;
      f_rptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_data_q[i] <= 32'h0;
        q_pc_q[i]   <= 32'h0;
        f_pc_q[i]   <= 32'h0;
      end
    end else begin
      pc_q          <= pc_d;
      run_q         <= run_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      q_wptr_q      <= q_wptr_d;
      q_rptr_q      <= q_rptr_d;
      f_wptr_q      <= f_wptr_d;
      f_rptr_q      <= f_rptr_d;
      q_data_q      <= q_data_d;
      q_pc_q        <= q_pc_d;
      f_pc_q        <= f_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// Main instance (RESET_PC=0, DEPTH=2) sits behind a queued memory model that
// can hold back responses; a second instance (RESET_PC=FFFF_FFF8) runs
// against an always-ready one-cycle memory to exercise PC wrap.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc, inst_pc4;

  logic        w_req_valid, w_resp_valid, w_inst_valid;
  logic [31:0] w_req_addr, w_resp_data, w_inst, w_inst_pc, w_inst_pc4;

  int errors = 0;
  int checks = 0;

  logic        mem_hold;
  logic [31:0] mem_a;
  logic [31:0] pend[$];
  logic [31:0] req_log[$];
  logic [31:0] del_pc[$];
  logic [31:0] del_data[$];
  logic [31:0] del_pc4[$];
  logic [31:0] w_req_log[$];
  logic [31:0] w_del_pc[$];
  logic [31:0] w_del_pc4[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_pc4        (inst_pc4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (w_req_valid),
    .imem_req_ready  (1'b1),
    .imem_req_addr   (w_req_addr),
    .imem_resp_valid (w_resp_valid),
    .imem_resp_data  (w_resp_data),
    .redirect        (1'b0),
    .redirect_pc     (32'h0),
    .inst_valid      (w_inst_valid),
    .inst_ready      (1'b1),
    .inst            (w_inst),
    .inst_pc         (w_inst_pc),
    .inst_pc4        (w_inst_pc4)
  );

  // Memory for the main instance: in-order, data = addr >> 2, one cycle
  // after acceptance unless mem_hold parks responses.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        req_log.push_back(imem_req_addr);
      end
      if (!mem_hold && pend.size() != 0) begin
        mem_a = pend.pop_front();
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= {2'b00, mem_a[31:2]};
      end else begin
        imem_resp_valid <= 1'b0;
        imem_resp_data  <= 32'h0;
      end
    end
  end

  // Memory for the wrap instance: always ready, one-cycle response.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_resp_valid <= 1'b0;
      w_resp_data  <= 32'h0;
    end else begin
      if (w_req_valid) w_req_log.push_back(w_req_addr);
      w_resp_valid <= w_req_valid;
      w_resp_data  <= w_req_addr ^ 32'hA5A5_0000;
    end
  end

  // Record decode handshakes.
  always @(posedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      del_pc.push_back(inst_pc);
      del_data.push_back(inst);
      del_pc4.push_back(inst_pc4);
    end
    if (rst_n && w_inst_valid) begin
      w_del_pc.push_back(w_inst_pc);
      w_del_pc4.push_back(w_inst_pc4);
    end
  end

  // Occupancy invariant: queued + in-flight never exceeds DEPTH.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (32'(u_dut.count_q) + 32'(u_dut.outstanding_q) > 32'd2) begin
        errors++;
        $display("FAIL invariant: count+outstanding=%0d, limit 2",
                 32'(u_dut.count_q) + 32'(u_dut.outstanding_q));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    req_log.delete();
    del_pc.delete();
    del_data.delete();
    del_pc4.delete();
    w_req_log.delete();
    w_del_pc.delete();
    w_del_pc4.delete();
  endtask

  // Leaves the bench at the negedge of the first cycle that may fetch.
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    checks++; if (inst_pc4 !== 32'h0) begin errors++; $display("FAIL reset_inst_pc4: got %h want 0", inst_pc4); end
    checks++; if (w_req_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_wrap_addr: got %h want fffffff8", w_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3]   = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp_data [3] = '{32'h0, 32'h1, 32'h2};
    int n = 0;
    inst_ready = 1'b1; imem_req_ready = 1'b1; mem_hold = 1'b0;
    do_reset();
    while (del_pc.size() < 3 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (del_pc.size() < 3) begin
      errors++; $display("FAIL stream_timeout: got %0d deliveries want 3", del_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (del_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, del_pc[i], exp_pc[i]); end
        checks++; if (del_data[i] !== exp_data[i]) begin errors++; $display("FAIL stream_inst[%0d]: got %h want %h", i, del_data[i], exp_data[i]); end
        checks++; if (del_pc4[i] !== exp_pc[i] + 32'd4) begin errors++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, del_pc4[i], exp_pc[i] + 32'd4); end
        checks++; if (req_log[i] !== exp_pc[i]) begin errors++; $display("FAIL stream_req[%0d]: got %h want %h", i, req_log[i], exp_pc[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    int n = 0;
    inst_ready = 1'b0; imem_req_ready = 1'b1; mem_hold = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_inst_valid: got %b want 1", inst_valid); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h want 0", inst_pc); end
    inst_ready = 1'b1;
    while ((del_pc.size() < 3 || req_log.size() < 3) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (del_pc.size() < 3 || req_log.size() < 3) begin
      errors++; $display("FAIL bp_timeout: got %0d deliveries %0d requests want 3", del_pc.size(), req_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (del_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL bp_pc[%0d]: got %h want %h", i, del_pc[i], exp_pc[i]); end
        checks++; if (req_log[i] !== exp_pc[i]) begin errors++; $display("FAIL bp_req[%0d]: got %h want %h", i, req_log[i], exp_pc[i]); end
      end
    end
  endtask

  task automatic test_req_stall();
    inst_ready = 1'b1; imem_req_ready = 1'b0; mem_hold = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, imem_req_valid); end
      checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL stall_addr[%0d]: got %h want 0", i, imem_req_addr); end
      @(negedge clk);
    end
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL stall_req_count: got %0d want 0", req_log.size()); end
    imem_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (imem_req_addr !== 32'h4) begin errors++; $display("FAIL stall_addr_after: got %h want 4", imem_req_addr); end
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL stall_req_after: got %0d want 1", req_log.size()); end
  endtask

  task automatic test_redirect();
    int n = 0;
    inst_ready = 1'b1; imem_req_ready = 1'b1; mem_hold = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h10;
    @(negedge clk);
    redirect = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_log.size() != 2) begin
      errors++; $display("FAIL redir_inflight: got %0d requests want 2", req_log.size());
    end else begin
      checks++; if (req_log[0] !== 32'h10) begin errors++; $display("FAIL redir_req0: got %h want 10", req_log[0]); end
      checks++; if (req_log[1] !== 32'h14) begin errors++; $display("FAIL redir_req1: got %h want 14", req_log[1]); end
    end
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    del_pc.delete(); del_data.delete(); del_pc4.delete();
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want 100", imem_req_addr); end
    mem_hold = 1'b0;
    while (del_pc.size() < 2 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (del_pc.size() < 2 || req_log.size() < 3) begin
      errors++; $display("FAIL redir_timeout: got %0d deliveries want 2", del_pc.size());
    end else begin
      checks++; if (del_pc[0] !== 32'h100) begin errors++; $display("FAIL redir_pc0: got %h want 100", del_pc[0]); end
      checks++; if (del_data[0] !== 32'h40) begin errors++; $display("FAIL redir_inst0: got %h want 40", del_data[0]); end
      checks++; if (del_pc[1] !== 32'h104) begin errors++; $display("FAIL redir_pc1: got %h want 104", del_pc[1]); end
      checks++; if (del_data[1] !== 32'h41) begin errors++; $display("FAIL redir_inst1: got %h want 41", del_data[1]); end
      checks++; if (req_log[2] !== 32'h100) begin errors++; $display("FAIL redir_req2: got %h want 100", req_log[2]); end
    end
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] exp_pc [3]   = '{32'h200, 32'h204, 32'h208};
    logic [31:0] exp_data [3] = '{32'h80, 32'h81, 32'h82};
    int n = 0;
    inst_ready = 1'b1; imem_req_ready = 1'b1; mem_hold = 1'b0;
    do_reset();
    while (!(imem_resp_valid && inst_valid) && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!(imem_resp_valid && inst_valid)) begin
      errors++; $display("FAIL same_setup: no cycle with response and head valid");
    end
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    req_log.delete(); del_pc.delete(); del_data.delete(); del_pc4.delete();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL same_cleared: got inst_valid %b want 0", inst_valid); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL same_head_pc: got %h want 0", inst_pc); end
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL same_addr: got %h want 200", imem_req_addr); end
    n = 0;
    while (del_pc.size() < 3 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (del_pc.size() < 3) begin
      errors++; $display("FAIL same_timeout: got %0d deliveries want 3", del_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (del_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL same_pc[%0d]: got %h want %h", i, del_pc[i], exp_pc[i]); end
        checks++; if (del_data[i] !== exp_data[i]) begin errors++; $display("FAIL same_inst[%0d]: got %h want %h", i, del_data[i], exp_data[i]); end
      end
      checks++; if (req_log[0] !== 32'h200) begin errors++; $display("FAIL same_req0: got %h want 200", req_log[0]); end
    end
  endtask

  task automatic test_wrap_async();
    logic [31:0] exp_w [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    int n = 0;
    inst_ready = 1'b1; imem_req_ready = 1'b1; mem_hold = 1'b0;
    do_reset();
    while ((w_req_log.size() < 3 || w_del_pc.size() < 2) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (w_req_log.size() < 3 || w_del_pc.size() < 2) begin
      errors++; $display("FAIL wrap_timeout: got %0d requests want 3", w_req_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (w_req_log[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_req[%0d]: got %h want %h", i, w_req_log[i], exp_w[i]); end
      end
      checks++; if (w_del_pc[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1: got %h want fffffffc", w_del_pc[1]); end
      checks++; if (w_del_pc4[1] !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h want 0", w_del_pc4[1]); end
    end
    n = 0;
    while (!inst_valid && n < 50) begin @(negedge clk); n++; end
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL async_setup: got inst_valid %b want 1", inst_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL async_inst_valid: got %b want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL async_inst: got %h want 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL async_inst_pc: got %h want 0", inst_pc); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL async_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (w_req_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL async_wrap_pc: got %h want fffffff8", w_req_addr); end
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    n = 0;
    while (req_log.size() < 2 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (req_log.size() < 2) begin
      errors++; $display("FAIL async_restart_timeout: got %0d requests want 2", req_log.size());
    end else begin
      checks++; if (req_log[0] !== 32'h0) begin errors++; $display("FAIL async_restart0: got %h want 0", req_log[0]); end
      checks++; if (req_log[1] !== 32'h4) begin errors++; $display("FAIL async_restart1: got %h want 4", req_log[1]); end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_wrap_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
